// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and stream byte width.
package imem_loader_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone
  } state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-serial loader for the instruction memory; holds the CPU in reset until a clean load.
// Define IMEM_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [ByteW-1:0]  in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ByteW-1:0]  wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e             state_q, state_d;
  logic [ByteW-1:0]   len_q, len_d;
  logic [ByteW-1:0]   cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ByteW-1:0]   wr_data_q, wr_data_d;
  logic               accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [ByteW-1:0]   sum_q, sum_d;
  logic               err_q, err_d;
`endif

  // in_ready is decoded purely from registered state, so it never depends on in_valid.
  assign in_ready = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLen;
          cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      StLen: begin
        if (accept) begin
          len_d   = in_data;
          state_d = StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
        end
      end
      StData: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_W'(cnt_q);
          wr_data_d = in_data;
          cnt_d     = cnt_q + 8'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_data;
          if (cnt_q == len_q) state_d = StCsum;
`else
          if (cnt_q == len_q) state_d = StDone;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          err_d   = (sum_q + in_data) != 8'd0;
          state_d = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign done     = (state_q == StDone);
  // Release the CPU only from DONE with a clean load.
  assign cpu_hold = !(done && !error);

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader that writes the instruction memory of the 8-bit non-pipelined processor; it is the write side of the instruction memory that the program counter and fetch path read. The loader accepts a length-prefixed byte stream over a valid/ready handshake and issues one registered write per accepted instruction byte. It holds the processor in reset (`cpu_hold`) until a load completes cleanly.

## Interface
- `ADDR_W`, default 8: instruction memory address width; must be ≥ 8.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  single-cycle pulse; begins a load when in IDLE or DONE.
- `in_valid`  input  1  source has a byte on `in_data`.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `wr_en`  output  1  instruction memory write strobe.
- `wr_addr`  output  ADDR_W  write address.
- `wr_data`  output  8  write data.
- `cpu_hold`  output  1  holds PC and processor in reset while high.
- `done`  output  1  load finished (level, until next `start` or `reset`).
- `error`  output  1  checksum mismatch on last load (level).

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE.
- IDLE: `in_ready`=0; `start` → LEN, clear `done`, `error`, byte counter, running sum.
- LEN: `in_ready`=1; on handshake (`in_valid && in_ready`) latch L = `in_data`; byte count N = L+1 (1..256); → DATA. Add L to running sum.
- DATA: `in_ready`=1; each handshake writes byte k (k = 0..N-1) to address k; add byte to sum (mod 256). After byte N-1 → CSUM if checksum compiled in, else DONE.
- CSUM: `in_ready`=1; on handshake add checksum byte; final sum ≠ 0 → `error`=1. → DONE.
- DONE: `done`=1; `cpu_hold` = `error`; `in_ready`=0; `start` → LEN (re-load, `cpu_hold` reasserts same cycle as the state change).
- `start` in LEN/DATA/CSUM is ignored. Bytes offered outside LEN/DATA/CSUM are not accepted.
- Addresses never wrap: N ≤ 256 ≤ 2^ADDR_W; upper address bits are zero.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `error`=0; state IDLE.
- `in_ready` is a function of state only (registered); no combinational path from `in_valid`.
- Write latency: handshake in cycle t → `wr_en`=1 with address/data in cycle t+1, exactly one cycle wide.
- Throughput: one byte per cycle when `in_valid` held high.
- Last data handshake at t: `done` rises at t+1 (no checksum) with `wr_en` for that byte also at t+1; `cpu_hold` falls at t+1.
- `in_valid` low stalls any state with no side effect.
- `reset` mid-load: return to IDLE next edge, `wr_en` low, `cpu_hold`=1; partially written memory is not cleared.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: CSUM state present; one trailing byte such that (L + all data + checksum) mod 256 = 0; mismatch sets `error` and keeps `cpu_hold`=1.
- Not defined: no CSUM state, no running sum; `error` tied 0; DATA → DONE directly.

## Structure
- Shared package: state enum (IDLE, LEN, DATA, CSUM, DONE) and constant for byte width 8.
- Single module; no sub-module needed (counter and sum are inline registers).

## Test plan
- Reset then `start`, stream L=0x02, bytes 0xA1,0xB2,0xC3 back-to-back → writes (0,A1),(1,B2),(2,C3) on consecutive cycles, `done`=1 and `cpu_hold`=0 one cycle after last handshake.
- Same load with `in_valid` toggling every other cycle → identical writes, no duplicates, `wr_en` exactly three pulses.
- Checksum build: L=0x01, data 0x10,0x20, checksum 0xCF → `error`=0, `cpu_hold`=0; checksum 0x00 → `error`=1, `cpu_hold`=1, `done`=1.
- L=0xFF, 256 bytes value = address → last write to address 255, no address wrap, `done` after 256th write.
- `reset` asserted after 2 of 4 data bytes → next cycle IDLE, `in_ready`=0, `cpu_hold`=1, no further `wr_en`; `start` in mid-load ignored.
- From DONE, `start` with L=0x00, data 0x55 → `cpu_hold` reasserts immediately, single write (0,55), `done` again.
